// File: rtl/seq_match_sched.sv
// seq_match_sched: round-robin scheduler that time-shares one external
// overlapping Moore "1001" detector between two requesters. A granted word
// is shifted out MSB-first on det_x, the detector's match pulses are counted
// (saturating), the detector is flushed with zeros so consecutive words never
// interact, and the count is returned tagged with the requester id.
module seq_match_sched #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_data,
  output logic          req1_ready,
  output logic          det_x,
  input  logic          det_y,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [CW-1:0] rsp_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_BIT   = IW'(W - 1);
  localparam logic [1:0]    LAST_FLUSH = 2'd2;

  logic [1:0]    state;
  logic          ptr;
  logic          id;
  logic [W-1:0]  shift_reg;
  logic [IW-1:0] bit_idx;
  logic [1:0]    flush_idx;
  logic [CW-1:0] count;

  logic          in_idle;
  logic          accept;
  logic          grant_id;
  logic [W-1:0]  grant_data;
  logic          sample_y;
  logic          count_full;

  // Round-robin grant: ptr only matters when both requesters are valid.
  assign in_idle    = (state == IDLE);
  assign req0_ready = in_idle & req0_valid & (~req1_valid | ~ptr);
  assign req1_ready = in_idle & req1_valid & (~req0_valid |  ptr);
  assign accept     = req0_ready | req1_ready;
  assign grant_id   = req1_ready;
  assign grant_data = req1_ready ? req1_data : req0_data;

  // det_y is meaningful one cycle after each data bit: SHIFT k>=1 sees bits
  // 0..W-2, FLUSH cycle 0 sees the last data bit. SHIFT k=0 is stale context.
  assign sample_y   = ((state == SHIFT) && (bit_idx != '0)) ||
                      ((state == FLUSH) && (flush_idx == 2'd0));
  assign count_full = &count;

  assign rsp_valid  = (state == RESP);

  // Main sequencing: IDLE -> SHIFT (W) -> FLUSH (3) -> RESP (1) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_idx   <= '0;
      flush_idx <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            bit_idx <= '0;
          end
        end
        SHIFT: begin
          if (bit_idx == LAST_BIT) begin
            state     <= FLUSH;
            flush_idx <= 2'd0;
          end else begin
            bit_idx <= bit_idx + IW'(1);
          end
        end
        FLUSH: begin
          if (flush_idx == LAST_FLUSH) begin
            state <= RESP;
          end else begin
            flush_idx <= flush_idx + 2'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Round-robin pointer and owner id are updated only on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
      id  <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant_id;
      id  <= grant_id;
    end
  end

  // Serializer: the MSB goes out directly on accept, the rest are pre-shifted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      det_x     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= {grant_data[W-2:0], 1'b0};
            det_x     <= grant_data[W-1];
          end else begin
            det_x <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_idx == LAST_BIT) begin
            det_x <= 1'b0;
          end else begin
            det_x     <= shift_reg[W-1];
            shift_reg <= shift_reg << 1;
          end
        end
        default: begin
          det_x <= 1'b0;
        end
      endcase
    end
  end

  // Match counter: cleared on accept, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (in_idle && accept) begin
      count <= '0;
    end else if (sample_y && det_y && !count_full) begin
      count <= count + CW'(1);
    end
  end

  // Response registers load on the way into RESP and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id    <= 1'b0;
      rsp_count <= '0;
    end else if ((state == FLUSH) && (flush_idx == LAST_FLUSH)) begin
      rsp_id    <= id;
      rsp_count <= count;
    end
  end

endmodule
